// File: rtl/commit_queue_n.sv
// commit_queue_n: in-order commit buffer with N completion ports, notify handshake and branch flush.
// Define COMMIT_QUEUE_BYPASS_EN to let a completing head retire in its completion cycle.
module commit_queue_n #(
  parameter int DEPTH  = 64,
  parameter int N_CMPL = 3,
  parameter int DATA_W = 32,
  parameter int PC_W   = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_en_i,
  output logic                       push_ready_o,
  input  logic                       push_kind_i,
  input  logic [7:0]                 push_dest_logic_i,
  input  logic [1:0]                 push_notify_i,
  input  logic [PC_W-1:0]            push_pc_i,
  output logic [7:0]                 push_id_o,
  input  logic [N_CMPL-1:0]          cmpl_en_i,
  input  logic [N_CMPL*8-1:0]        cmpl_id_i,
  input  logic [N_CMPL*DATA_W-1:0]   cmpl_data_i,
  input  logic [N_CMPL-1:0]          cmpl_raise_i,
  input  logic [N_CMPL-1:0]          cmpl_taken_i,
  input  logic [N_CMPL*PC_W-1:0]     cmpl_new_pc_i,
  output logic [1:0]                 notify_req_o,
  input  logic                       notify_ack_i,
  output logic                       commit_wb_en_o,
  output logic [7:0]                 commit_dest_logic_o,
  output logic [DATA_W-1:0]          commit_data_o,
  output logic                       flush_en_o,
  output logic [PC_W-1:0]            flush_pc_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic              kind;
    logic [7:0]        dest;
    logic [1:0]        ntf;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
    logic              raise;
    logic              taken;
    logic [PC_W-1:0]   npc;
  } ent_t;

  ent_t              ent_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, fin_q;
  logic [AW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q;
  logic              wb_en_q, flush_en_q;
  logic [7:0]        dest_q;
  logic [DATA_W-1:0] data_q;
  logic [PC_W-1:0]   fpc_q;

  logic [N_CMPL-1:0]             c_ok;
  logic [N_CMPL-1:0][AW-1:0]     c_idx;
  logic [N_CMPL-1:0][DATA_W-1:0] c_data;
  logic [N_CMPL-1:0][PC_W-1:0]   c_npc;

  // Ids beyond DEPTH can never name a live slot, so they are dropped like invalid targets.
  for (genvar g = 0; g < N_CMPL; g++) begin : g_port
    assign c_ok[g]   = (cmpl_id_i[g*8 +: 8] >> AW) == 8'd0;
    assign c_idx[g]  = cmpl_id_i[g*8 +: AW];
    assign c_data[g] = cmpl_data_i[g*DATA_W +: DATA_W];
    assign c_npc[g]  = cmpl_new_pc_i[g*PC_W +: PC_W];
  end

  ent_t head, byp_ent, ret_ent, push_ent;
  logic head_v, head_f, byp_hit, retire, flush_now, push_acc;

  assign head   = ent_q[head_q];
  assign head_v = valid_q[head_q];
  assign head_f = fin_q[head_q];

  always_comb begin
    byp_hit = 1'b0;
    byp_ent = head;
`ifdef COMMIT_QUEUE_BYPASS_EN
    for (int i = 0; i < N_CMPL; i++) begin
      if (cmpl_en_i[i] && c_ok[i] && c_idx[i] == head_q) begin
        byp_hit       = 1'b1;
        byp_ent.data  = c_data[i];
        byp_ent.raise = cmpl_raise_i[i];
        byp_ent.taken = cmpl_taken_i[i];
        byp_ent.npc   = c_npc[i];
      end
    end
`endif
  end

  // An already-finished head always retires from its stored fields.
  assign ret_ent   = head_f ? head : byp_ent;
  assign retire    = head_v && (head_f ? (head.ntf == 2'b00 || notify_ack_i)
                                       : (byp_hit && head.ntf == 2'b00));
  assign flush_now = retire && ret_ent.kind && ret_ent.raise;

  assign push_ready_o = !reset_i && (count_q < CW'(DEPTH)) && !flush_now;
  assign push_acc     = push_en_i && push_ready_o;
  assign push_id_o    = 8'(tail_q);
  assign notify_req_o = (head_v && head_f && !head.kind) ? head.ntf : 2'b00;

  always_comb begin
    push_ent       = '0;
    push_ent.kind  = push_kind_i;
    push_ent.dest  = push_dest_logic_i;
    push_ent.ntf   = push_kind_i ? 2'b00 : push_notify_i;
    push_ent.pc    = push_pc_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      fin_q      <= '0;
      wb_en_q    <= 1'b0;
      dest_q     <= '0;
      data_q     <= '0;
      flush_en_q <= 1'b0;
      fpc_q      <= '0;
    end else begin
      wb_en_q <= retire && !ret_ent.kind;
      if (retire && !ret_ent.kind) begin
        dest_q <= ret_ent.dest;
        data_q <= ret_ent.data;
      end
      flush_en_q <= flush_now;
      if (flush_now)
        fpc_q <= ret_ent.taken ? ret_ent.npc : ret_ent.pc + PC_W'(1);
      // Ascending loop: the highest port naming an id lands last and wins.
      for (int i = 0; i < N_CMPL; i++) begin
        if (cmpl_en_i[i] && c_ok[i] && valid_q[c_idx[i]]) begin
          fin_q[c_idx[i]] <= 1'b1;
          if (ent_q[c_idx[i]].kind) begin
            ent_q[c_idx[i]].raise <= cmpl_raise_i[i];
            ent_q[c_idx[i]].taken <= cmpl_taken_i[i];
            ent_q[c_idx[i]].npc   <= c_npc[i];
          end else begin
            ent_q[c_idx[i]].data  <= c_data[i];
          end
        end
      end
      if (push_acc) begin
        ent_q[tail_q]   <= push_ent;
        valid_q[tail_q] <= 1'b1;
        fin_q[tail_q]   <= 1'b0;
        tail_q          <= tail_q + AW'(1);
      end
      if (flush_now) begin
        valid_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (retire) begin
          valid_q[head_q] <= 1'b0;
          head_q          <= head_q + AW'(1);
        end
        count_q <= count_q + CW'(push_acc) - CW'(retire);
      end
    end
  end

  assign commit_wb_en_o      = wb_en_q;
  assign commit_dest_logic_o = dest_q;
  assign commit_data_o       = data_q;
  assign flush_en_o          = flush_en_q;
  assign flush_pc_o          = fpc_q;
  assign count_o             = count_q;
endmodule

// File: tb/tb_commit_queue_n.sv
// tb_commit_queue_n: directed stimulus against a queue-level reference model plus literal spot checks.
module tb_commit_queue_n;
  localparam int DEPTH = 4, N_CMPL = 3, DATA_W = 32, PC_W = 16;
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef COMMIT_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0, reset;
  logic push_en, push_ready, push_kind;
  logic [7:0] push_dest_logic, push_id;
  logic [1:0] push_notify, notify_req;
  logic [PC_W-1:0] push_pc, flush_pc;
  logic [N_CMPL-1:0] cmpl_en, cmpl_raise, cmpl_taken;
  logic [N_CMPL*8-1:0] cmpl_id;
  logic [N_CMPL*DATA_W-1:0] cmpl_data;
  logic [N_CMPL*PC_W-1:0] cmpl_new_pc;
  logic notify_ack, commit_wb_en, flush_en;
  logic [7:0] commit_dest_logic;
  logic [DATA_W-1:0] commit_data;
  logic [CW-1:0] count;

  commit_queue_n #(.DEPTH(DEPTH), .N_CMPL(N_CMPL), .DATA_W(DATA_W), .PC_W(PC_W)) dut (
    .clk_i(clk), .reset_i(reset), .push_en_i(push_en), .push_ready_o(push_ready),
    .push_kind_i(push_kind), .push_dest_logic_i(push_dest_logic), .push_notify_i(push_notify),
    .push_pc_i(push_pc), .push_id_o(push_id), .cmpl_en_i(cmpl_en), .cmpl_id_i(cmpl_id),
    .cmpl_data_i(cmpl_data), .cmpl_raise_i(cmpl_raise), .cmpl_taken_i(cmpl_taken),
    .cmpl_new_pc_i(cmpl_new_pc), .notify_req_o(notify_req), .notify_ack_i(notify_ack),
    .commit_wb_en_o(commit_wb_en), .commit_dest_logic_o(commit_dest_logic),
    .commit_data_o(commit_data), .flush_en_o(flush_en), .flush_pc_o(flush_pc), .count_o(count));

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the live entries as an ordered queue, oldest first.
  typedef struct {
    int id; bit kind; bit [7:0] dest; bit [1:0] ntf; bit [PC_W-1:0] pc;
    bit fin; bit [DATA_W-1:0] data; bit raise; bit taken; bit [PC_W-1:0] npc;
  } ent_t;
  ent_t mq[$];
  int mtail = 0;
  bit e_wb = 0, e_fl = 0;
  bit [7:0] e_dest = 0;
  bit [DATA_W-1:0] e_data = 0;
  bit [PC_W-1:0] e_fpc = 0;

  function automatic void eval(output bit ret, output ent_t re);
    ent_t h, b;
    bit hit = 0;
    ret = 0;
    re = '{default: 0};
    if (mq.size() == 0) return;
    h = mq[0]; b = h; re = h;
    for (int i = 0; i < N_CMPL; i++)
      if (cmpl_en[i] && int'(cmpl_id[i*8 +: 8]) == h.id) begin
        hit = 1;
        b.data = cmpl_data[i*DATA_W +: DATA_W]; b.raise = cmpl_raise[i];
        b.taken = cmpl_taken[i]; b.npc = cmpl_new_pc[i*PC_W +: PC_W];
      end
    ret = h.fin && (h.ntf == 0 || notify_ack);
    if (BYP && !h.fin && hit && h.ntf == 0) begin ret = 1; re = b; end
  endfunction

  initial begin
    bit ret, fl, acc;
    ent_t re, t;
    forever begin
      @(posedge clk);
      if (reset) begin
        mq.delete(); mtail = 0;
        e_wb = 0; e_dest = 0; e_data = 0; e_fl = 0; e_fpc = 0;
      end else begin
        eval(ret, re);
        fl  = ret && re.kind && re.raise;
        acc = push_en && mq.size() < DEPTH && !fl;
        e_wb = ret && !re.kind;
        if (e_wb) begin e_dest = re.dest; e_data = re.data; end
        e_fl = fl;
        if (fl) e_fpc = re.taken ? re.npc : re.pc + 1'b1;
        for (int i = 0; i < N_CMPL; i++)
          if (cmpl_en[i])
            foreach (mq[k])
              if (mq[k].id == int'(cmpl_id[i*8 +: 8])) begin
                t = mq[k]; t.fin = 1;
                if (t.kind) begin
                  t.raise = cmpl_raise[i]; t.taken = cmpl_taken[i];
                  t.npc = cmpl_new_pc[i*PC_W +: PC_W];
                end else t.data = cmpl_data[i*DATA_W +: DATA_W];
                mq[k] = t;
              end
        if (fl) begin
          mq.delete(); mtail = 0;
        end else begin
          if (ret) void'(mq.pop_front());
          if (acc) begin
            t = '{default: 0};
            t.id = mtail; t.kind = push_kind; t.dest = push_dest_logic;
            t.ntf = push_kind ? 2'b00 : push_notify; t.pc = push_pc;
            mq.push_back(t);
            mtail = (mtail + 1) % DEPTH;
          end
        end
      end
      @(negedge clk);
      eval(ret, re);
      fl = ret && re.kind && re.raise;
      chk("m_push_ready", push_ready, 64'(!reset && mq.size() < DEPTH && !fl));
      chk("m_push_id", push_id, 64'(mtail));
      chk("m_count", count, 64'(mq.size()));
      chk("m_notify_req", notify_req,
          (mq.size() > 0 && mq[0].fin && !mq[0].kind) ? 64'(mq[0].ntf) : 64'd0);
      chk("m_wb_en", commit_wb_en, 64'(e_wb));
      if (e_wb) begin
        chk("m_wb_dest", commit_dest_logic, 64'(e_dest));
        chk("m_wb_data", commit_data, 64'(e_data));
      end
      chk("m_flush_en", flush_en, 64'(e_fl));
      if (e_fl) chk("m_flush_pc", flush_pc, 64'(e_fpc));
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic go();
    tick();
    push_en = 0; cmpl_en = '0; cmpl_raise = '0; cmpl_taken = '0; notify_ack = 0;
  endtask
  task automatic set_push(bit k, bit [7:0] d, bit [1:0] n, bit [PC_W-1:0] pc);
    push_en = 1; push_kind = k; push_dest_logic = d; push_notify = n; push_pc = pc;
  endtask
  task automatic push(bit k, bit [7:0] d, bit [1:0] n, bit [PC_W-1:0] pc);
    set_push(k, d, n, pc); go();
  endtask
  task automatic cmpl(int p, bit [7:0] id, bit [DATA_W-1:0] dat, bit r, bit tk, bit [PC_W-1:0] np);
    cmpl_en[p] = 1; cmpl_id[p*8 +: 8] = id; cmpl_data[p*DATA_W +: DATA_W] = dat;
    cmpl_raise[p] = r; cmpl_taken[p] = tk; cmpl_new_pc[p*PC_W +: PC_W] = np;
  endtask
  task automatic do_reset();
    reset = 1; go(); go(); reset = 0;
  endtask
  task automatic wait_wb(string nm, bit [7:0] d, bit [DATA_W-1:0] dat);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (commit_wb_en === 1'b1) begin
        chk({nm, "_dest"}, commit_dest_logic, 64'(d));
        chk({nm, "_data"}, commit_data, 64'(dat));
        return;
      end
    end
    checks++; errs++;
    $display("FAIL %s: commit_wb_en never rose, expected data %0h", nm, dat);
  endtask
  task automatic wait_flush(string nm, bit [PC_W-1:0] pc);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (flush_en === 1'b1) begin chk(nm, flush_pc, 64'(pc)); return; end
    end
    checks++; errs++;
    $display("FAIL %s: flush_en never rose, expected pc %0h", nm, pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; push_en = 0; push_kind = 0; push_dest_logic = 0; push_notify = 0; push_pc = 0;
    cmpl_en = '0; cmpl_id = '0; cmpl_data = '0; cmpl_raise = '0; cmpl_taken = '0;
    cmpl_new_pc = '0; notify_ack = 0;
    go(); go();
    @(negedge clk);
    chk("rst_ready", push_ready, 0); chk("rst_count", count, 0);
    chk("rst_wb_en", commit_wb_en, 0); chk("rst_flush", flush_en, 0);
    reset = 0;
    @(negedge clk);
    chk("ready_after_rst", push_ready, 1);

    // out-of-order completion, in-order commit
    push(0, 8'd1, 0, 0); push(0, 8'd2, 0, 0); push(0, 8'd3, 0, 0);
    cmpl(0, 2, 32'hA, 0, 0, 0); go();
    cmpl(0, 0, 32'hB, 0, 0, 0); go();
    cmpl(0, 1, 32'hC, 0, 0, 0); go();
    wait_wb("ooo0", 8'd1, 32'hB); wait_wb("ooo1", 8'd2, 32'hC); wait_wb("ooo2", 8'd3, 32'hA);
    chk("ooo_count", count, 0);

    // full queue, no same-cycle credit, id wrap (reset mid-operation first)
    push(0, 8'h20, 0, 0);
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(0, 8'(8'h20 + i), 0, 0);
    @(negedge clk);
    chk("full_ready", push_ready, 0); chk("full_count", count, 4);
    cmpl(0, 0, 32'h55, 0, 0, 0); go();
    set_push(0, 8'h30, 0, 0);
    @(negedge clk);
    chk("full_retire_ready", push_ready, 0);
    tick();
    @(negedge clk);
    chk("full_next_ready", push_ready, 1); chk("full_wrap_id", push_id, 0);
    go();

    // mispredict flush, not taken
    do_reset();
    push(0, 8'd5, 0, 0); push(1, 8'd0, 0, 16'h0010); push(0, 8'd6, 0, 0); push(0, 8'd7, 0, 0);
    cmpl(1, 0, 32'h77, 0, 0, 0); cmpl(0, 1, 0, 1, 0, 16'h1234); go();
    go();
    set_push(0, 8'd9, 0, 0);
    @(negedge clk);
    chk("flush_push_block", push_ready, 0);
    go();
    cmpl(0, 2, 32'h99, 0, 0, 0); set_push(0, 8'd8, 0, 0);
    @(negedge clk);
    chk("flush_en", flush_en, 1); chk("flush_pc", flush_pc, 16'h0011);
    chk("flush_id", push_id, 0); chk("flush_count", count, 0);
    go();
    cmpl(0, 0, 32'hD, 0, 0, 0); go();
    wait_wb("post_flush", 8'd8, 32'hD);

    // notify handshake
    push(0, 8'd4, 2'b01, 0);
    cmpl(2, 1, 32'h44, 0, 0, 0); go();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); chk("notify_hold", notify_req, 2'b01); go();
    end
    notify_ack = 1;
    @(negedge clk); chk("notify_ack_cyc", notify_req, 2'b01);
    go();
    @(negedge clk);
    chk("notify_wb_en", commit_wb_en, 1); chk("notify_data", commit_data, 32'h44);
    chk("notify_clear", notify_req, 0);

    // dest 0 still reported; two ports on one id, highest wins
    push(0, 8'd0, 0, 0); push(0, 8'd3, 0, 0);
    cmpl(1, 2, 32'h5, 0, 0, 0); go();
    cmpl(0, 3, 32'h11, 0, 0, 0); cmpl(2, 3, 32'h22, 0, 0, 0); go();
    wait_wb("dest0", 8'd0, 32'h5); wait_wb("port_prio", 8'd3, 32'h22);

    // branch raise=0 is silent; raise with not-taken wraps pc; taken uses target
    push(1, 0, 0, 16'h0040); push(1, 0, 0, 16'hFFFF);
    cmpl(0, 0, 0, 0, 1, 16'h0100); cmpl(1, 1, 0, 1, 0, 16'h2222); go();
    wait_flush("wrap_pc", 16'h0000);
    push(1, 0, 0, 16'h0005);
    cmpl(0, 0, 0, 1, 1, 16'hBEEF); go();
    wait_flush("taken_pc", 16'hBEEF);

    // completion-to-commit latency
    push(0, 8'h11, 0, 0); go();
    cmpl(0, 0, 32'h66, 0, 0, 0);
    @(negedge clk); chk("lat_t0", commit_wb_en, 0);
    go();
    @(negedge clk); chk("lat_t1", commit_wb_en, 64'(BYP));
    tick();
    @(negedge clk); chk("lat_t2", commit_wb_en, 64'(!BYP));

    // reset overrides a pending notify
    push(0, 8'd2, 2'b10, 0);
    cmpl(0, 1, 32'h3, 0, 0, 0); go();
    @(negedge clk); chk("pend_notify", notify_req, 2'b10);
    reset = 1; go();
    @(negedge clk);
    chk("rst_notify", notify_req, 0); chk("rst_mid_count", count, 0);
    reset = 0; go(); go();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
